// File: rtl/debug_pkg.sv
// Shared definitions for the debug-unit controllers: request codes, FSM encoding
// and a width helper for counters.
package debug_pkg;

  localparam logic [5:0] ID_MEMORY_DUMP   = 6'b000000;
  localparam logic [5:0] ID_REGISTER_DUMP = 6'b000001;
  localparam logic [5:0] ID_PC_DUMP       = 6'b000010;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_READ = ST_READ,
    S_WAIT = ST_WAIT,
    S_SEND = ST_SEND,
    S_DONE = ST_DONE
  } dump_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/debug_chunk_serializer.sv
// Holds one memory word and presents it as zero-extended NB_LATCH-bit chunks,
// LSB chunk first, over a ready/valid handshake.
module debug_chunk_serializer
  import debug_pkg::*;
#(
  parameter int NB_LATCH         = 32,
  parameter int NB_INPUT_SIZE    = 32,
  parameter int NB_CONTROL_FRAME = 32
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        load,
  input  logic                        clear,
  input  logic [NB_INPUT_SIZE-1:0]    data,
  input  logic                        ready,
  output logic                        valid,
  output logic [NB_CONTROL_FRAME-1:0] frame,
  output logic                        last
);

  localparam int N_CHUNKS     = (NB_INPUT_SIZE + NB_LATCH - 1) / NB_LATCH;
  localparam int NB_PADDED    = N_CHUNKS * NB_LATCH;
  localparam int NB_CHUNK_CNT = (clog2(N_CHUNKS) > 0) ? clog2(N_CHUNKS) : 1;

  logic [NB_PADDED-1:0]    data_reg;
  logic [NB_CHUNK_CNT-1:0] chunk_cnt;
  logic [NB_LATCH-1:0]     chunk;

  // The padded register makes the top chunk's unused bits read back as zero.
  assign chunk = data_reg[int'(chunk_cnt)*NB_LATCH +: NB_LATCH];
  assign frame = NB_CONTROL_FRAME'(chunk);
  assign last  = (chunk_cnt == NB_CHUNK_CNT'(N_CHUNKS - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      data_reg  <= '0;
      chunk_cnt <= '0;
      valid     <= 1'b0;
    end else if (clear) begin
      chunk_cnt <= '0;
      valid     <= 1'b0;
    end else if (load) begin
      data_reg  <= NB_PADDED'(data);
      chunk_cnt <= '0;
      valid     <= 1'b1;
    end else if (valid && ready) begin
      if (last) begin
        chunk_cnt <= '0;
        valid     <= 1'b0;
      end else begin
        chunk_cnt <= chunk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_control_memory_dump.sv
// Dumps N_WORDS consecutive data-memory words to the frame interface, one chunk
// per frame, starting on a rising edge of the matching debug request.
module debug_control_memory_dump
  import debug_pkg::*;
#(
  parameter int          NB_LATCH         = 32,
  parameter int          NB_INPUT_SIZE    = 32,
  parameter int          NB_CONTROL_FRAME = 32,
  parameter logic [5:0]  CONTROLLER_ID    = ID_MEMORY_DUMP,
  parameter int          N_WORDS          = 64,
  parameter int          BASE_ADDR        = 0,
  parameter int          NB_ADDR          = 10,
  parameter int          MEM_LATENCY      = 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [5:0]                  i_request_select,
  input  logic [NB_INPUT_SIZE-1:0]    i_data_from_mips,
  input  logic                        i_tx_ready,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_interface,
  output logic                        o_frame_valid,
  output logic                        o_mem_re,
  output logic [NB_ADDR-1:0]          o_mem_addr,
  output logic                        o_writing,
  output logic                        o_done
);

  localparam int         NB_WORD_CNT = (clog2(N_WORDS) > 0) ? clog2(N_WORDS) : 1;
  localparam logic [1:0] WAIT_LAST   = (MEM_LATENCY > 0) ? 2'(MEM_LATENCY - 1) : 2'd0;

  dump_state_t            state;
  logic [NB_WORD_CNT-1:0] word_cnt;
  logic [1:0]             wait_cnt;
  logic                   match_r;
  logic                   request_match;
  logic                   start;
  logic                   abort;
  logic                   capture;
  logic                   sent_last;
  logic                   ser_last;
  logic [NB_ADDR-1:0]     next_addr;

  assign request_match = (i_request_select == CONTROLLER_ID);
  assign start         = request_match & ~match_r;
  assign abort         = ((state == S_READ) || (state == S_WAIT) || (state == S_SEND))
                         && !request_match;
  // Data is sampled on the exact cycle the memory drives it, so no skid buffer is needed.
  assign capture       = !abort && ((MEM_LATENCY == 0) ? (state == S_READ)
                                    : ((state == S_WAIT) && (wait_cnt == WAIT_LAST)));
  assign sent_last     = o_frame_valid && i_tx_ready && ser_last;
  assign next_addr     = NB_ADDR'(BASE_ADDR + int'(word_cnt) + 1);

  debug_chunk_serializer #(
    .NB_LATCH         (NB_LATCH),
    .NB_INPUT_SIZE    (NB_INPUT_SIZE),
    .NB_CONTROL_FRAME (NB_CONTROL_FRAME)
  ) u_serializer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .load    (capture),
    .clear   (abort),
    .data    (i_data_from_mips),
    .ready   (i_tx_ready),
    .valid   (o_frame_valid),
    .frame   (o_frame_to_interface),
    .last    (ser_last)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      wait_cnt   <= '0;
      match_r    <= 1'b0;
      o_mem_re   <= 1'b0;
      o_mem_addr <= '0;
      o_writing  <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      match_r  <= request_match;
      o_mem_re <= 1'b0;
      o_done   <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        word_cnt  <= '0;
        wait_cnt  <= '0;
        o_writing <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_READ;
              word_cnt   <= '0;
              o_mem_re   <= 1'b1;
              o_mem_addr <= NB_ADDR'(BASE_ADDR);
              o_writing  <= 1'b1;
            end
          end
          S_READ: begin
            wait_cnt <= '0;
            state    <= (MEM_LATENCY == 0) ? S_SEND : S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == WAIT_LAST) state <= S_SEND;
            else wait_cnt <= wait_cnt + 1'b1;
          end
          S_SEND: begin
            if (sent_last) begin
              if (word_cnt == NB_WORD_CNT'(N_WORDS - 1)) begin
                state  <= S_DONE;
                o_done <= 1'b1;
              end else begin
                state      <= S_READ;
                word_cnt   <= word_cnt + 1'b1;
                o_mem_re   <= 1'b1;
                o_mem_addr <= next_addr;
              end
            end
          end
          S_DONE: begin
            state     <= S_IDLE;
            word_cnt  <= '0;
            o_writing <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_control_memory_dump.sv
// Directed scoreboard bench: a 4-word/64-bit/latency-1 dump instance and a
// 1-word/40-bit/latency-3 instance for padding and latency alignment.
module tb_debug_control_memory_dump;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [5:0]  i_request_select = 6'h3F;
  logic [63:0] i_data_from_mips;
  logic        i_tx_ready = 1'b1;
  logic [31:0] o_frame_to_interface;
  logic        o_frame_valid;
  logic        o_mem_re;
  logic [9:0]  o_mem_addr;
  logic        o_writing;
  logic        o_done;

  logic [5:0]  req2 = 6'h3F;
  logic [39:0] data2;
  logic [31:0] frame2;
  logic        valid2;
  logic        mem_re2;
  logic [9:0]  addr2;
  logic        writing2;
  logic        done2;

  int n_compared   = 0;
  int n_mismatched = 0;
  int frames_seen  = 0;
  int reads_seen   = 0;
  int done_count   = 0;
  int frames2_seen = 0;
  int done2_count  = 0;
  int cyc          = 0;
  int re2_cycle    = 0;
  logic valid2_prev = 1'b0;

  logic [31:0] frame_q[$];
  logic [9:0]  addr_q[$];
  logic [31:0] frame2_q[$];

  logic        rd_valid1;
  logic [9:0]  rd_addr1;
  logic [31:0] rd_k;
  logic [2:0]  pipe2;

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;

  debug_control_memory_dump #(
    .NB_LATCH(32), .NB_INPUT_SIZE(64), .NB_CONTROL_FRAME(32), .CONTROLLER_ID(6'h00),
    .N_WORDS(4), .BASE_ADDR(8), .NB_ADDR(10), .MEM_LATENCY(1)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_request_select(i_request_select),
    .i_data_from_mips(i_data_from_mips), .i_tx_ready(i_tx_ready),
    .o_frame_to_interface(o_frame_to_interface), .o_frame_valid(o_frame_valid),
    .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr), .o_writing(o_writing), .o_done(o_done)
  );

  debug_control_memory_dump #(
    .NB_LATCH(32), .NB_INPUT_SIZE(40), .NB_CONTROL_FRAME(32), .CONTROLLER_ID(6'h00),
    .N_WORDS(1), .BASE_ADDR(5), .NB_ADDR(10), .MEM_LATENCY(3)
  ) dut2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_request_select(req2),
    .i_data_from_mips(data2), .i_tx_ready(1'b1),
    .o_frame_to_interface(frame2), .o_frame_valid(valid2),
    .o_mem_re(mem_re2), .o_mem_addr(addr2), .o_writing(writing2), .o_done(done2)
  );

  // Memory models: read data is only meaningful on the exact latency cycle.
  always @(posedge i_clock) begin
    rd_valid1 <= o_mem_re;
    rd_addr1  <= o_mem_addr;
    pipe2     <= {pipe2[1:0], mem_re2};
  end

  always_comb begin
    rd_k             = 32'(rd_addr1) - 32'd8;
    i_data_from_mips = rd_valid1 ? {32'hA + rd_k, 32'hB + rd_k} : 64'hDEAD_BEEF_DEAD_BEEF;
    data2            = pipe2[2] ? 40'hFF_1234_5678 : 40'hAA_DEAD_BEEF;
  end

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard for the main instance.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_mem_re) begin
        reads_seen++;
        check_value("mem_re_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) check_value("mem_addr", 64'(o_mem_addr), 64'(addr_q.pop_front()));
        check_value("writing_in_read", 64'(o_writing), 64'd1);
      end
      if (o_frame_valid && i_tx_ready) begin
        frames_seen++;
        check_value("frame_expected", 64'(frame_q.size() != 0), 64'd1);
        if (frame_q.size() != 0)
          check_value("frame", 64'(o_frame_to_interface), 64'(frame_q.pop_front()));
      end else if (o_frame_valid && frame_q.size() != 0) begin
        check_value("frame_hold", 64'(o_frame_to_interface), 64'(frame_q[0]));
      end
      if (o_done) begin
        done_count++;
        check_value("writing_in_done", 64'(o_writing), 64'd1);
      end
    end
  end

  // Scoreboard for the padded, latency-3 instance.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (mem_re2) re2_cycle = cyc;
      if (valid2 && !valid2_prev) check_value("latency2", 64'(cyc - re2_cycle), 64'd4);
      valid2_prev = valid2;
      if (valid2) begin
        frames2_seen++;
        check_value("frame2_expected", 64'(frame2_q.size() != 0), 64'd1);
        if (frame2_q.size() != 0) check_value("frame2", 64'(frame2), 64'(frame2_q.pop_front()));
      end
      if (done2) done2_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic push_dump();
    for (int k = 0; k < 4; k++) begin
      addr_q.push_back(10'(8 + k));
      frame_q.push_back(32'hB + 32'(k));
      frame_q.push_back(32'hA + 32'(k));
    end
  endtask

  task automatic apply_stimulus();
    i_request_select = 6'h3F;
    step(2);
    push_dump();
    i_request_select = 6'h00;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int target;
    int n;
    target = done_count + 1;
    n = 0;
    while (done_count < target && n < budget) begin
      @(posedge i_clock);
      n++;
    end
    #1;
    check_value(tag, 64'(done_count), 64'(target));
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(posedge i_clock);
      n++;
    end
    #1;
    check_value(tag, 64'(frames_seen), 64'(target));
  endtask

  task automatic check_output_idle(input string tag);
    check_value({tag, "_valid"},   64'(o_frame_valid), 64'd0);
    check_value({tag, "_mem_re"},  64'(o_mem_re), 64'd0);
    check_value({tag, "_addr"},    64'(o_mem_addr), 64'd0);
    check_value({tag, "_writing"}, 64'(o_writing), 64'd0);
    check_value({tag, "_done"},    64'(o_done), 64'd0);
    check_value({tag, "_frame"},   64'(o_frame_to_interface), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    step(3);
    check_output_idle("reset");
    i_reset = 1'b0;
    step(2);

    $display("[TB] basic dump");
    apply_stimulus();
    wait_done("basic_done", 200);
    check_value("basic_frames", 64'(frames_seen), 64'd8);
    check_value("basic_reads", 64'(reads_seen), 64'd4);
    step(2);
    check_value("basic_writing_low", 64'(o_writing), 64'd0);

    $display("[TB] level hold");
    step(200);
    check_value("hold_done", 64'(done_count), 64'd1);
    check_value("hold_reads", 64'(reads_seen), 64'd4);

    $display("[TB] backpressure");
    base = frames_seen;
    apply_stimulus();
    wait_frames("bp_first_chunk", base + 1, 100);
    i_tx_ready = 1'b0;
    step(5);
    check_value("bp_valid_held", 64'(o_frame_valid), 64'd1);
    check_value("bp_reads", 64'(reads_seen), 64'd5);
    i_tx_ready = 1'b1;
    wait_done("bp_done", 200);
    check_value("bp_frames", 64'(frames_seen - base), 64'd8);
    check_value("bp_total_reads", 64'(reads_seen), 64'd8);

    $display("[TB] abort");
    step(2);
    base = frames_seen;
    apply_stimulus();
    wait_frames("abort_three_frames", base + 3, 100);
    i_tx_ready = 1'b0;
    i_request_select = 6'h01;
    frame_q.delete();
    addr_q.delete();
    step(1);
    check_value("abort_valid_drop", 64'(o_frame_valid), 64'd0);
    check_value("abort_writing_drop", 64'(o_writing), 64'd0);
    i_tx_ready = 1'b1;
    step(20);
    check_value("abort_no_done", 64'(done_count), 64'd2);
    check_value("abort_no_frames", 64'(frames_seen - base), 64'd3);

    $display("[TB] re-request");
    apply_stimulus();
    wait_done("rereq_done", 200);
    check_value("rereq_queue_empty", 64'(frame_q.size()), 64'd0);

    $display("[TB] async reset");
    step(2);
    apply_stimulus();
    n = 0;
    while (!o_mem_re && n < 20) begin
      step(1);
      n++;
    end
    check_value("areset_read_seen", 64'(o_mem_re), 64'd1);
    step(1);
    #2;
    i_reset = 1'b1;
    #1;
    check_output_idle("areset");
    frame_q.delete();
    addr_q.delete();
    i_request_select = 6'h3F;
    step(2);
    i_reset = 1'b0;
    base = reads_seen;
    step(20);
    check_value("areset_idle_writing", 64'(o_writing), 64'd0);
    check_value("areset_idle_reads", 64'(reads_seen - base), 64'd0);
    check_value("areset_no_done", 64'(done_count), 64'd3);

    $display("[TB] padding and latency");
    frame2_q.push_back(32'h1234_5678);
    frame2_q.push_back(32'h0000_00FF);
    req2 = 6'h00;
    n = 0;
    while (done2_count < 1 && n < 100) begin
      @(posedge i_clock);
      n++;
    end
    #1;
    check_value("pad_done", 64'(done2_count), 64'd1);
    check_value("pad_frames", 64'(frames2_seen), 64'd2);
    check_value("pad_addr", 64'(addr2), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
